turf_ram_32768x3: RTL and testbench
===================================

// Module: turf_ram_32768x3
// PURPOSE
//  Single-port synchronous 32768 x 3-bit RAM holding the arena colour map, one word per cell.
//  Address packs {x[7:0], y[6:0]}.
//  Sits between the game's ram_update sequencer (read/claim/collide) and the display path.
//  After every reset, a built-in sweep clears the whole array to CLEAR_VAL, so each round starts on an empty board.
// PARAMETERS
//  ADDR_W     15      address width; DEPTH = 2**ADDR_W = 32768 words
//  DATA_W     3       word width (colour code; 000 = unclaimed, 111 = dead/crash)
//  CLEAR_VAL  3'b000  value written to every word by the reset sweep
// PORTS
//  clock    in   1       single clock; all state changes on its rising edge
//  resetn   in   1       synchronous, active-low reset
//  address  in   ADDR_W  word address {x,y}; all 32768 values valid, no out-of-range case
//  data     in   DATA_W  write data
//  wren     in   1       1 = write data to address this edge; 0 = read only
//  q        out  DATA_W  registered read data
//  ready    out  1       1 = sweep done, user port live; 0 = clearing
// BEHAVIOUR
//  - Reset is synchronous, active-low, single clock.
//    - At any rising edge with resetn=0: q<=0, ready<=0, sweep pointer<=0, state<=CLEAR.
//    - Array contents are not touched during reset.
//  - Power-up: the initial state is CLEAR with the pointer at 0 and ready=0, so the first sweep runs without a reset pulse.
//  - CLEAR state:
//    - Each edge with resetn=1 writes CLEAR_VAL to mem[ptr], then ptr<=ptr+1.
//    - User address, data and wren are ignored; q is held at 0.
//    - The edge that writes address 32767 moves to state RUN and sets ready<=1.
//    - The sweep is exactly 32768 edges after resetn rises. The pointer wraps to 0 and is unused in RUN.
//  - Reset during CLEAR aborts the sweep. The next sweep restarts at address 0.
//  - RUN state, every edge:
//    - If wren=1: mem[address] <= data.
//    - q <= mem[address] (read latency 1: q is valid after the edge that samples address).
//    - wren=0 leaves the array unchanged; q still updates.
//  - Read-during-write (wren=1, same edge): q follows the RUN_RDW_NEW_DATA_EN rule under CONFIGURATION.
//  - Width rules: address is used exactly as given (no wrap or truncation); data is stored unmodified.
//  - q changes only on clock edges and never glitches combinationally.
// CONFIGURATION
//  RUN_RDW_NEW_DATA_EN
//    - defined:   a write edge sets q <= data (write-through / new-data read).
//    - undefined: a write edge sets q <= previous mem[address] (old-data read). This is the default and matches the sequencer's read-then-write order.
//    - Has no effect during the CLEAR sweep.
// TESTING
//  1. Hold resetn=0 for 2 edges, then release. ready=0 for the next 32767 edges; ready=1 after edge 32768; q=0 throughout.
//  2. After ready: read 0x0000, 0x4F77 and 0x7FFF -> q=000 one edge after each address.
//  3. Write 3'b001 @0x4F77 (x=158, y=119), then read 0x4F77 -> q=001; read 0x0001 -> q=000.
//  4. Write 3'b010 @0x0001, then write 3'b111 @0x0001 with wren=1.
//     - macro undefined: q=010 after the second write.
//     - macro defined:   q=111.
//     - Either way, a following read returns 111.
//  5. Drive wren=1, data=101 during the sweep. No write lands: after ready, the address reads 000.
//  6. Write 110 @0x1234, then assert resetn=0 at sweep pointer 1000, then release. Sweep restarts at 0; after ready, 0x1234 reads 000.

Source files
------------

// File: rtl/turf_ram_32768x3.sv
// ---------------------------------------------------------------------------
// turf_ram_32768x3
//
// Single-port synchronous 32768 x 3-bit RAM that holds the arena colour map,
// one word per cell, addressed as {x[7:0], y[6:0]}. After every reset a
// built-in sweep writes CLEAR_VAL into every word, so each round starts on an
// empty board. The user port is ignored until the sweep finishes and ready
// goes high.
//
// Ports
//   clock    in   1       single clock, rising edge
//   resetn   in   1       synchronous, active-low reset
//   address  in   ADDR_W  word address {x,y}
//   data     in   DATA_W  write data
//   wren     in   1       1 = write data to address this edge
//   q        out  DATA_W  registered read data (latency 1)
//   ready    out  1       1 = sweep done, user port live
//
// Configuration macro
//   RUN_RDW_NEW_DATA_EN  defined   : a write edge returns the new data on q
//                        undefined : a write edge returns the old word on q
// ---------------------------------------------------------------------------
module turf_ram_32768x3 #(
  parameter int                 ADDR_W    = 15,
  parameter int                 DATA_W    = 3,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = 3'b000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // CLEAR is encoded as all-zero so a zero-initialised power-up lands in the
  // sweep with the pointer at 0, without needing a reset pulse.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] q_q,     q_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    q_d       = q_q;
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = data;

    if (state_q == ST_CLEAR) begin
      // Sweep owns the array; user inputs are ignored and q stays at zero.
      mem_we    = resetn;
      mem_addr  = ptr_q;
      mem_wdata = CLEAR_VAL;
      ptr_d     = ptr_q + ADDR_W'(1);
      q_d       = '0;
      if (ptr_q == LAST_ADDR) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    end else begin
      mem_we = resetn & wren;
`ifdef RUN_RDW_NEW_DATA_EN
      q_d = wren ? data : mem[address];
`else
      q_d = mem[address];
`endif
    end
  end

  // Control and read-data flops. The array itself is never reset; resetn only
  // restarts the sweep (the array write is gated off while resetn is low).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      q_q     <= q_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign q     = q_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_turf_ram_32768x3.sv
// ---------------------------------------------------------------------------
// tb_turf_ram_32768x3
//
// Scoreboard bench for turf_ram_32768x3. The stimulus process drives inputs
// on the falling edge and pushes the expected {q, ready} for the next rising
// edge into a queue tagged with that edge number. A separate monitor counts
// rising edges, samples the outputs 1 ns later and compares against every
// queue entry due on that edge.
// ---------------------------------------------------------------------------
module tb_turf_ram_32768x3;

  logic        clock;
  logic        resetn;
  logic [14:0] address;
  logic [2:0]  data;
  logic        wren;
  logic [2:0]  q;
  logic        ready;

  int edge_cnt = 0;
  int checks   = 0;
  int failures = 0;
  bit stim_done = 1'b0;

  int         sb_cyc  [$];
  logic [2:0] sb_q    [$];
  logic       sb_rdy  [$];
  string      sb_name [$];

  turf_ram_32768x3 dut (
    .clock   (clock),
    .resetn  (resetn),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q),
    .ready   (ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One call = one rising edge: inputs are driven on the falling edge and
  // sampled by the DUT on the following rising edge (edge_cnt + 1).
  task automatic applyStimulus(input logic rstn, input logic wr,
                               input logic [14:0] addr, input logic [2:0] dat);
    @(negedge clock);
    resetn  = rstn;
    wren    = wr;
    address = addr;
    data    = dat;
  endtask

  task automatic pushExpect(input string name, input int cyc,
                            input logic [2:0] exp_q, input logic exp_rdy);
    sb_cyc.push_back(cyc);
    sb_q.push_back(exp_q);
    sb_rdy.push_back(exp_rdy);
    sb_name.push_back(name);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] act_q,
                             input logic act_rdy, input logic [2:0] exp_q,
                             input logic exp_rdy);
    checks++;
    if (act_q !== exp_q) begin
      failures++;
      $display("[TB] FAIL %s q: got %b expected %b (edge %0d)", name, act_q, exp_q, edge_cnt);
    end
    checks++;
    if (act_rdy !== exp_rdy) begin
      failures++;
      $display("[TB] FAIL %s ready: got %b expected %b (edge %0d)", name, act_rdy, exp_rdy, edge_cnt);
    end
  endtask

  task automatic doRead(input string name, input logic [14:0] addr, input logic [2:0] exp_q);
    applyStimulus(1'b1, 1'b0, addr, 3'b000);
    pushExpect(name, edge_cnt + 1, exp_q, 1'b1);
  endtask

  task automatic doWrite(input string name, input logic [14:0] addr,
                         input logic [2:0] dat, input logic [2:0] exp_q);
    applyStimulus(1'b1, 1'b1, addr, dat);
    pushExpect(name, edge_cnt + 1, exp_q, 1'b1);
  endtask

  task automatic doReset(input string name);
    applyStimulus(1'b0, 1'b0, 15'h0000, 3'b000);
    pushExpect({name, " rst1"}, edge_cnt + 1, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b0, 15'h0000, 3'b000);
    pushExpect({name, " rst2"}, edge_cnt + 1, 3'b000, 1'b0);
  endtask

  // Full sweep after reset release: ready must stay low for 32767 edges and
  // rise on edge 32768. When inject is set, the user port tries to write 101
  // to 0x2222 in the middle of the sweep.
  task automatic doSweep(input string name, input bit inject);
    int s;
    applyStimulus(1'b1, 1'b0, 15'h0000, 3'b000);
    s = edge_cnt + 1;
    pushExpect({name, " sweep first"}, s,         3'b000, 1'b0);
    pushExpect({name, " sweep mid"},   s + 150,   3'b000, 1'b0);
    pushExpect({name, " sweep 32767"}, s + 32766, 3'b000, 1'b0);
    pushExpect({name, " sweep 32768"}, s + 32767, 3'b000, 1'b1);
    for (int i = 1; i < 32768; i++) begin
      if (inject && i >= 100 && i < 200)
        applyStimulus(1'b1, 1'b1, 15'h2222, 3'b101);
      else
        applyStimulus(1'b1, 1'b0, 15'(i), 3'b111);
    end
  endtask

  // Monitor: compares every scoreboard entry due on the current edge.
  initial begin
    forever begin
      @(posedge clock);
      edge_cnt++;
      #1;
      while (sb_cyc.size() > 0 && sb_cyc[0] <= edge_cnt) begin
        if (sb_cyc[0] < edge_cnt) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s missed: due edge %0d seen at edge %0d", sb_name[0], sb_cyc[0], edge_cnt);
        end else begin
          checkOutput(sb_name[0], q, ready, sb_q[0], sb_rdy[0]);
        end
        void'(sb_cyc.pop_front());
        void'(sb_q.pop_front());
        void'(sb_rdy.pop_front());
        void'(sb_name.pop_front());
      end
    end
  end

  initial begin
    logic [2:0] old_or_new;
    resetn  = 1'b0;
    wren    = 1'b0;
    address = '0;
    data    = '0;

    // Reset, full sweep with write attempts injected during clearing.
    doReset("t1");
    doSweep("t1", 1'b1);

    // Fresh board reads as unclaimed.
    doRead("t2 rd 0000", 15'h0000, 3'b000);
    doRead("t2 rd 4F77", 15'h4F77, 3'b000);
    doRead("t2 rd 7FFF", 15'h7FFF, 3'b000);

    // Claim a cell, read it back, neighbour untouched.
`ifdef RUN_RDW_NEW_DATA_EN
    old_or_new = 3'b001;
`else
    old_or_new = 3'b000;
`endif
    doWrite("t3 wr 4F77", 15'h4F77, 3'b001, old_or_new);
    doRead("t3 rd 4F77", 15'h4F77, 3'b001);
    doRead("t3 rd 0001", 15'h0001, 3'b000);

    // Back-to-back writes to one address exercise read-during-write.
`ifdef RUN_RDW_NEW_DATA_EN
    doWrite("t4 wr1 0001", 15'h0001, 3'b010, 3'b010);
    doWrite("t4 wr2 0001", 15'h0001, 3'b111, 3'b111);
`else
    doWrite("t4 wr1 0001", 15'h0001, 3'b010, 3'b000);
    doWrite("t4 wr2 0001", 15'h0001, 3'b111, 3'b010);
`endif
    doRead("t4 rd 0001", 15'h0001, 3'b111);

    // Writes attempted during the sweep never landed.
    doRead("t5 rd 2222", 15'h2222, 3'b000);
    doRead("t5 rd 4F77 again", 15'h4F77, 3'b001);

    // Claim 0x1234, then abort a sweep at pointer 1000 and restart it.
`ifdef RUN_RDW_NEW_DATA_EN
    doWrite("t6 wr 1234", 15'h1234, 3'b110, 3'b110);
`else
    doWrite("t6 wr 1234", 15'h1234, 3'b110, 3'b000);
`endif
    doRead("t6 rd 1234", 15'h1234, 3'b110);
    doReset("t6a");
    applyStimulus(1'b1, 1'b0, 15'h0000, 3'b000);
    pushExpect("t6a sweep first", edge_cnt + 1, 3'b000, 1'b0);
    for (int i = 1; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 15'h1234, 3'b000);
    end
    doReset("t6b");
    doSweep("t6b", 1'b0);
    doRead("t6 rd 1234 cleared", 15'h1234, 3'b000);
    doRead("t6 rd 0001 cleared", 15'h0001, 3'b000);
    doRead("t6 rd 4F77 cleared", 15'h4F77, 3'b000);

    applyStimulus(1'b1, 1'b0, 15'h0000, 3'b000);
    stim_done = 1'b1;
  end

  // Bounded drain of the scoreboard, then the summary.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && sb_cyc.size() > 0; i++) begin
      @(posedge clock);
      #2;
    end
    while (sb_cyc.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s not checked: due edge %0d, now edge %0d", sb_name[0], sb_cyc[0], edge_cnt);
      void'(sb_cyc.pop_front());
      void'(sb_q.pop_front());
      void'(sb_rdy.pop_front());
      void'(sb_name.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
